// File: rtl/adder_chunk_seq.sv
// WIDTH-bit add with carry-in, computed LSB-first through one shared CHUNK-bit slice.
// Valid/ready on both sides; one operation is in flight at a time.
module adder_chunk_seq #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("adder_chunk_seq: WIDTH must be a nonzero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [IDXW-1:0]  idx_r;
  logic             carry_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [CHUNK-1:0] slice_a_s;
  logic [CHUNK-1:0] slice_b_s;
  logic [CHUNK:0]   slice_s;

  // Shared ripple slice: current chunk of each operand plus the carried bit
  always_comb begin
    slice_a_s = a_r[idx_r*CHUNK +: CHUNK];
    slice_b_s = b_r[idx_r*CHUNK +: CHUNK];
    slice_s   = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{CHUNK{1'b0}}, carry_r};
  end

  // Controller: accept, step chunks LSB-first, hold result until the sink takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      idx_r       <= {IDXW{1'b0}};
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            carry_r    <= cin;
            idx_r      <= {IDXW{1'b0}};
            sum_r      <= {WIDTH{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_RUN;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_r[idx_r*CHUNK +: CHUNK] <= slice_s[CHUNK-1:0];
          carry_r                     <= slice_s[CHUNK];
          if (idx_r == LAST_IDX) begin
            cout_r      <= slice_s[CHUNK];
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            idx_r       <= idx_r + IDXW'(1);
          end
        end
        ST_DONE: begin
          // in_ready stays low here: a new accept waits for the edge after the handshake
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_adder_chunk_seq.sv
// Bench for adder_chunk_seq: transaction-level reference model with per-cycle compare,
// directed scenarios with hand-computed results, then randomized traffic.
module tb_adder_chunk_seq;

  localparam int WIDTH  = 12;
  localparam int CHUNK  = 3;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  adder_chunk_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 computing, 2 result offered
  int          m_ph = 0;
  int          m_left = 0;
  logic [12:0] m_exp = '0;
  logic [11:0] m_sum = '0;
  logic        m_cout = 1'b0;
  bit          m_sv = 1'b0;
  bit          m_init = 1'b0;
  int          cyc = 0;
  int          acc_q[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_ph = 0; m_sum = '0; m_cout = 1'b0; m_sv = 1'b1; m_init = 1'b1;
    end else if (m_ph == 0) begin
      if (in_valid) begin
        m_ph   = 1;
        m_left = NCHUNK;
        m_exp  = {1'b0, a} + {1'b0, b} + {12'd0, cin};
        m_sv   = 1'b0;
        acc_q.push_back(cyc);
      end
    end else if (m_ph == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_ph = 2; {m_cout, m_sum} = m_exp; m_sv = 1'b1;
      end
    end else begin
      if (out_ready) begin
        m_ph = 0; m_sv = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", int'(in_ready), int'(m_ph == 0));
      chk("busy", int'(busy), int'(m_ph != 0));
      chk("out_valid", int'(out_valid), int'(m_ph == 2));
      if (m_sv) begin
        chk("sum", int'(sum), int'(m_sum));
        chk("cout", int'(cout), int'(m_cout));
      end
    end
  end

  // Issue one op with out_ready=1; checks latency and the literal result
  task automatic op(input logic [11:0] ta, input logic [11:0] tb_v, input logic tc,
                    input logic [11:0] es, input logic ec);
    int lat;
    in_valid = 1'b1; a = ta; b = tb_v; cin = tc; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 12'($urandom); b = 12'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, NCHUNK);
    chk("op_sum", int'(sum), int'(es));
    chk("op_cout", int'(cout), int'(ec));
    @(posedge clk); #1;
    chk("ready_after_hs", int'(in_ready), 1);
    chk("valid_after_hs", int'(out_valid), 0);
  endtask

  initial begin
    int n;
    int res_q[$];
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_cout", int'(cout), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1);
    op(12'h7FF, 12'h800, 1'b1, 12'h000, 1'b1);

    // ABC+123+1: after the first RUN edge the low chunk is 4+3+1 -> 0
    in_valid = 1'b1; a = 12'hABC; b = 12'h123; cin = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("abc_e1_low", int'(sum[2:0]), 0);
    n = 1;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("abc_sum", int'(sum), 12'hBE0);
    chk("abc_cout", int'(cout), 0);
    @(posedge clk); #1;

    // Back-pressure with in_valid held and operands toggling
    acc_q.delete();
    in_valid = 1'b1; a = 12'h005; b = 12'h003; cin = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (!out_valid && n < 20) begin
      a = ~a; b = ~b; @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_sum", int'(sum), 12'h008);
      chk("bp_cout", int'(cout), 0);
      chk("bp_in_ready", int'(in_ready), 0);
      a = 12'($urandom); b = 12'($urandom);
      @(posedge clk); #1;
    end
    chk("bp_single_accept", acc_q.size(), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", int'(in_ready), 1);
    chk("bp_release_valid", int'(out_valid), 0);

    // Reset after E2 of an add
    in_valid = 1'b1; a = 12'h123; b = 12'h456; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_sum", int'(sum), 0);
    chk("mid_rst_cout", int'(cout), 0);
    op(12'h100, 12'h0FF, 1'b0, 12'h1FF, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    acc_q.delete();
    in_valid = 1'b1; a = 12'h001; b = 12'h001; cin = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 12'hFFE; b = 12'h001; cin = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (acc_q.size() >= 2) in_valid = 1'b0;
      @(posedge clk); #1;
      if (out_valid) res_q.push_back(int'({cout, sum}));
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc_q.size(), 2);
    if (acc_q.size() >= 2) chk("b2b_spacing", acc_q[1] - acc_q[0], 6);
    chk("b2b_valid_cycles", res_q.size(), 2);
    if (res_q.size() >= 2) begin
      chk("b2b_res0", res_q[0], 13'h0002);
      chk("b2b_res1", res_q[1], 13'h1000);
    end

    // Randomized traffic, occasional reset
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      a         = 12'($urandom);
      b         = 12'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
